// File: rtl/cnn_window3x3_linebuf.sv
// cnn_window3x3_linebuf
//   Streaming 3x3 window generator. Raster-order pixels arrive over a
//   valid/ready handshake; the two previous rows are kept in internal line
//   buffers and every interior 3x3 window is emitted packed on one bus with a
//   valid/busy handshake toward the MAC stage.
//
// Ports
//   iClk, iRst     clock, synchronous active-high reset
//   iEn            clock enable; when low all state is frozen
//   iPixel         input pixel, channel k at [k*CH_W +: CH_W]
//   iPixelValid    iPixel is valid
//   oPixelReady    block can accept a pixel (combinational, ignores iEn)
//   oWin           window, tap t at [t*DATA_W +: DATA_W], t=0 top-left,
//                  row-major, t=8 bottom-right
//   oValid         oWin holds a new window
//   iBusy          MAC not ready; oWin/oValid are held
//   oFrameDone     one-cycle pulse after the last window of a frame is consumed
//   oStallCnt      saturating stall-cycle count (only with WIN_STAT_EN)
//
// Build option
//   WIN_STAT_EN    adds oStallCnt and its counter
module cnn_window3x3_linebuf #(
    parameter int CH_W  = 8,
    parameter int CH_N  = 3,
    parameter int IMG_W = 480,
    parameter int IMG_H = 5,
    parameter int CNT_W = 17
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEn,
    input  logic [CH_N*CH_W-1:0]     iPixel,
    input  logic                     iPixelValid,
    output logic                     oPixelReady,
    output logic [9*CH_N*CH_W-1:0]   oWin,
    output logic                     oValid,
    input  logic                     iBusy,
    output logic                     oFrameDone
`ifdef WIN_STAT_EN
    ,
    output logic [CNT_W-1:0]         oStallCnt
`endif
);

    localparam int DATA_W = CH_N * CH_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_LAST = 1'b1;

    if (IMG_W < 3 || IMG_H < 3 || CNT_W < 1) begin : gBadParam
        $error("cnn_window3x3_linebuf: IMG_W/IMG_H must be >= 3 and CNT_W >= 1");
    end

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [0:0]        state;
    logic [DATA_W-1:0] lb0 [IMG_W];   // previous row
    logic [DATA_W-1:0] lb1 [IMG_W];   // row before that
    logic [DATA_W-1:0] win [9];

    logic accept;
    logic consume;
    logic colLast;
    logic rowLast;
    logic qualify;

    assign oPixelReady = ~(oValid & iBusy);
    assign accept      = iEn & iPixelValid & oPixelReady;
    assign consume     = iEn & oValid & ~iBusy;
    assign colLast     = (col == COL_W'(IMG_W - 1));
    assign rowLast     = (row == ROW_W'(IMG_H - 1));
    assign qualify     = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    for (genvar t = 0; t < 9; t++) begin : gTap
        assign oWin[t*DATA_W +: DATA_W] = win[t];
    end

    // Line buffers carry no reset: every entry is rewritten before it can
    // reach a qualifying window.
    always_ff @(posedge iClk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= iPixel;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            col        <= '0;
            row        <= '0;
            state      <= S_RUN;
            oValid     <= 1'b0;
            oFrameDone <= 1'b0;
            for (int unsigned t = 0; t < 9; t++) begin
                win[t] <= '0;
            end
        end else begin
            oFrameDone <= 1'b0;
            if (iEn) begin
                if (accept) begin
                    // Shift every row left; new right column is read from the
                    // line buffers before their update this same cycle.
                    for (int unsigned r = 0; r < 3; r++) begin
                        win[3*r]     <= win[3*r + 1];
                        win[3*r + 1] <= win[3*r + 2];
                    end
                    win[2] <= lb1[col];
                    win[5] <= lb0[col];
                    win[8] <= iPixel;

                    if (colLast) begin
                        col <= '0;
                        row <= rowLast ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end

                // A consume and a qualifying accept together keep oValid high.
                if (accept && qualify) begin
                    oValid <= 1'b1;
                end else if (!iBusy) begin
                    oValid <= 1'b0;
                end

                case (state)
                    S_RUN: begin
                        if (accept && colLast && rowLast) begin
                            state <= S_LAST;
                        end
                    end
                    default: begin
                        if (consume) begin
                            oFrameDone <= 1'b1;
                            state      <= S_RUN;
                        end
                    end
                endcase
            end
        end
    end

`ifdef WIN_STAT_EN
    always_ff @(posedge iClk) begin
        if (iRst || oFrameDone) begin
            oStallCnt <= '0;
        end else if (iEn && oValid && iBusy && (oStallCnt != '1)) begin
            oStallCnt <= oStallCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/cnn_window3x3_linebuf.md
Name: cnn_window3x3_linebuf

Overview:
- Streaming successor to the BRAM-polling 3x3 window generator.
- Accepts one raster-order pixel per enabled cycle over a valid/ready handshake and keeps the two previous image rows in internal line buffers, so no input-memory address generation is needed.
- Emits every interior 3x3 window packed on one bus, with a valid/busy handshake toward the MAC stage.
- Generalised over channel count, channel width and image size.

Parameters:
- CH_W, 8, bits per channel
- CH_N, 3, channels per pixel; DATA_W = CH_N*CH_W (24 at defaults, RGB888)
- IMG_W, 480, pixels per row; must be >= 3
- IMG_H, 5, rows per frame; must be >= 3
- CNT_W, 17, width of oStallCnt (optional feature only)

Ports:
- iClk, in, 1, clock
- iRst, in, 1, synchronous active-high reset
- iEn, in, 1, clock enable; when low, all state is frozen
- iPixel, in, DATA_W, input pixel; channel k is at [k*CH_W +: CH_W]
- iPixelValid, in, 1, iPixel is valid
- oPixelReady, out, 1, block can accept a pixel
- oWin, out, 9*DATA_W, window; tap t is at [t*DATA_W +: DATA_W], t=0 top-left, row-major, t=8 bottom-right
- oValid, out, 1, oWin holds a new window
- iBusy, in, 1, MAC not ready; oWin/oValid must be held
- oFrameDone, out, 1, one-cycle pulse after the last window of a frame is consumed
- oStallCnt, out, CNT_W, saturating count of stall cycles (only with WIN_STAT_EN)

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset values:
  - oValid=0, oWin=0, oFrameDone=0, oStallCnt=0
  - column/row counters=0, window registers=0
  - line-buffer contents are not reset; they are never observed before being rewritten.
- oPixelReady = !(oValid & iBusy). It is combinational and independent of iEn.
- Accept = iEn & iPixelValid & oPixelReady.
- On accept of pixel (r,c), both updated in the same cycle:
  - Line buffers: lb1[c] <= lb0[c], lb0[c] <= iPixel.
  - Window: all three window rows shift one column left; the new right column is {lb1[c], lb0[c], iPixel} (top, middle, bottom), read before the update.
- Counters: c increments on each accept; at c=IMG_W-1 it wraps to 0 and r increments. At (IMG_H-1, IMG_W-1) both wrap to 0 (new frame).
- Output valid and latency:
  - An accept with r>=2 and c>=2 sets oValid=1 one cycle later.
  - oWin then equals pixels rows r-2..r, cols c-2..c.
  - Latency is exactly 1 enabled cycle.
  - Windows never straddle a row boundary.
- Windows per frame: (IMG_W-2)*(IMG_H-2); 1434 at defaults.
- Backpressure:
  - While oValid=1 and iBusy=1, oWin/oValid hold and no pixel is accepted.
  - oValid clears on the first enabled cycle with iBusy=0 and no new qualifying accept.
  - A consume and a qualifying accept in the same cycle keep oValid=1 and load the new window.
- iEn=0: no accept, no state change, and oFrameDone is not generated; outputs hold.
- FSM:
  - S_RUN: normal streaming.
  - S_LAST: entered on accept of the final frame pixel. It waits for that window to be consumed (oValid & !iBusy, with iEn=1), then pulses oFrameDone for one cycle and returns to S_RUN.
  - In S_LAST, oPixelReady follows the same rule, so the next frame may start immediately.
- Reset mid-frame: everything returns to reset values and the next accepted pixel is treated as (0,0). Partial-frame windows are discarded.
- Channels are never mixed or modified; the block does no arithmetic on pixel data.

Optional Feature:
- Macro: WIN_STAT_EN.
- Defined:
  - oStallCnt increments on every enabled cycle with oValid & iBusy.
  - It saturates at 2^CNT_W-1.
  - It clears on iRst and on the oFrameDone pulse.
- Undefined: the oStallCnt port and its logic are absent.

Test Plan:
- Bench parameters IMG_W=6, IMG_H=4, CH_N=3; pixel value = {r,c,r^c} in 8-bit channels; iEn=1; iBusy=0 -> exactly 8 oValid pulses. The first occurs 1 cycle after accept of (2,2), with tap0=(0,0) and tap8=(2,2). Single oFrameDone after the 8th.
- Same frame with iBusy held high for 5 cycles at the 3rd window -> oWin stable for those 5 cycles, oPixelReady=0, no pixel lost, sequence identical to the no-stall case. With WIN_STAT_EN: oStallCnt=5, cleared after oFrameDone.
- iEn toggling 1,0,1,0 with iPixelValid=1 -> pixels accepted only on iEn=1 cycles; window contents identical to the continuous run.
- Two back-to-back frames with no gap -> 16 windows, 2 oFrameDone pulses. The first window of frame 2 contains only frame-2 pixels.
- iRst asserted after 10 accepts (mid row 1), then a full frame -> exactly 8 windows with correct contents. oValid=0 and oWin=0 on the cycle after reset.
- Default parameters (480x5) random pixels -> 1434 windows, all matching the reference model.
